// File: rtl/alu_pkg.sv
// Shared types for the XOR ALU result path.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Exports RESULT_W, OPERAND_W, TAG_W and result_entry_t.
package alu_pkg;

  localparam int RESULT_W  = 32;
  localparam int OPERAND_W = 5;
  localparam int TAG_W     = 8;

  // One buffered ALU result as delivered to the consumer.
  typedef struct packed {
    logic [RESULT_W-1:0] result;
    logic                balance;
    logic [TAG_W-1:0]    tag;
    logic                ext_err;
  } result_entry_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Small circular FIFO of result entries with registered occupancy flags.
// Latency: one cycle from push into an empty FIFO to not_empty; no bypass.
// Backpressure: caller must not push when full unless it pops in the same cycle.
// Ports: clk, flush (sync clear of pointers/occupancy), push/wr_entry, pop/rd_entry,
//        not_empty and full (both registered from next-cycle occupancy).
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  result_entry_t wr_entry,
  output result_entry_t rd_entry,
  output logic          not_empty,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  result_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic [AW:0]   occ_nxt;

  always_comb begin
    occ_nxt = occ;
    case ({push, pop})
      2'b10:   occ_nxt = occ + 1'b1;
      2'b01:   occ_nxt = occ - 1'b1;
      default: occ_nxt = occ;
    endcase
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers are AW bits wide, so incrementing wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      not_empty <= 1'b0;
      full      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ       <= occ_nxt;
      not_empty <= (occ_nxt != '0);
      full      <= (occ_nxt == FULL_OCC);
    end
  end

  assign rd_entry = not_empty ? mem[rd_ptr] : '0;

endmodule

// File: rtl/alu_result_collector.sv
// Captures XOR ALU results, buffers them and hands them out over valid/ready.
// Latency: one cycle from accepted input to out_valid; no same-cycle bypass.
// Backpressure: input cannot stall; entries arriving while full (and not popping) are dropped and counted.
// Ports: clk, reset/clear (sync, active-high), in_valid/in_result/in_balance,
//        out_valid/out_ready/out_result/out_balance/out_tag/out_ext_err, full,
//        balanced_count, dropped_count, overflow. Tag width is alu_pkg::TAG_W.
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16,
  parameter int DROP_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                in_valid,
  input  logic [RESULT_W-1:0] in_result,
  input  logic                in_balance,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RESULT_W-1:0] out_result,
  output logic                out_balance,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_ext_err,
  output logic                full,
  output logic [CNT_W-1:0]    balanced_count,
  output logic [DROP_W-1:0]   dropped_count,
  output logic                overflow
);

  logic          flush;
  logic          pop;
  logic          push;
  logic          drop;
  logic          ext_err;
  logic [TAG_W-1:0] tag_cnt;
  result_entry_t wr_entry;
  result_entry_t rd_entry;

  assign flush = reset | clear;
  assign pop   = out_valid & out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push  = in_valid & (~full | pop);
  assign drop  = in_valid & full & ~pop;

  // A valid result is a sign-extended OPERAND_W-bit value; flag anything else.
  assign ext_err = (in_result[RESULT_W-1:OPERAND_W] !=
                    {(RESULT_W-OPERAND_W){in_result[OPERAND_W-1]}});

  always_comb begin
    wr_entry         = '0;
    wr_entry.result  = in_result;
    wr_entry.balance = in_balance;
    wr_entry.tag     = tag_cnt;
    wr_entry.ext_err = ext_err;
  end

  alu_result_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .wr_entry  (wr_entry),
    .rd_entry  (rd_entry),
    .not_empty (out_valid),
    .full      (full)
  );

  // Tags advance only on accepted entries, so drops leave no gap in the sequence.
  always_ff @(posedge clk) begin
    if (flush) begin
      tag_cnt        <= '0;
      balanced_count <= '0;
      dropped_count  <= '0;
      overflow       <= 1'b0;
    end else begin
      if (push) begin
        tag_cnt <= tag_cnt + 1'b1;
        if (in_balance && (balanced_count != '1)) begin
          balanced_count <= balanced_count + 1'b1;
        end
      end
      if (drop) begin
        overflow <= 1'b1;
        if (dropped_count != '1) begin
          dropped_count <= dropped_count + 1'b1;
        end
      end
    end
  end

  assign out_result  = rd_entry.result;
  assign out_balance = rd_entry.balance;
  assign out_tag     = rd_entry.tag;
  assign out_ext_err = rd_entry.ext_err;

endmodule
